// File: rtl/evaluate_taper_if.sv
// Evaluation taper bus: request/score inputs from the search side, blended result back.
interface evaluate_taper_if #(
    parameter int EVAL_WIDTH     = 32,
    parameter int MATERIAL_WIDTH = 32
);
    // Request side
    logic                             eval_valid;
    logic                             clear_eval;
    logic signed [EVAL_WIDTH-1:0]     eval_mg;
    logic signed [EVAL_WIDTH-1:0]     eval_eg;
    logic        [MATERIAL_WIDTH-1:0] material_white;
    logic        [MATERIAL_WIDTH-1:0] material_black;
    logic                             insufficient_material;
    logic                             white_to_move;

    // Result side
    logic signed [EVAL_WIDTH-1:0]     taper_eval;
    logic        [8:0]                taper_phase;
    logic                             taper_valid;

    // Requester: drives the position, reads the result
    modport master (
        output eval_valid,
        output clear_eval,
        output eval_mg,
        output eval_eg,
        output material_white,
        output material_black,
        output insufficient_material,
        output white_to_move,
        input  taper_eval,
        input  taper_phase,
        input  taper_valid
    );

    // Evaluator: reads the position, drives the result
    modport slave (
        input  eval_valid,
        input  clear_eval,
        input  eval_mg,
        input  eval_eg,
        input  material_white,
        input  material_black,
        input  insufficient_material,
        input  white_to_move,
        output taper_eval,
        output taper_phase,
        output taper_valid
    );
endinterface

// File: rtl/evaluate_taper.sv
// Tapered evaluation: blends middlegame and endgame scores by a material-derived phase
// over a four-stage multi-cycle datapath, then saturates and flips to side-to-move view.
module evaluate_taper #(
    parameter int EVAL_WIDTH     = 0,
    parameter int MATERIAL_WIDTH = 32,
    parameter int MATERIAL_EG    = 1000,
    parameter int MATERIAL_SHIFT = 4
) (
    input logic              clk,
    input logic              reset,
    evaluate_taper_if.slave  bus
);

    localparam int TotW   = MATERIAL_WIDTH + 1;
    localparam int ProdW  = EVAL_WIDTH + 10;
    localparam int BlendW = EVAL_WIDTH + 2;

    localparam logic [TotW-1:0] MatEg     = TotW'(MATERIAL_EG);
    localparam logic [TotW-1:0] PhaseFull = TotW'(256);

    // Largest magnitude representable symmetrically, so negation never overflows
    localparam logic signed [BlendW-1:0] SatMax = BlendW'((64'sd1 <<< (EVAL_WIDTH - 1)) - 64'sd1);
    localparam logic signed [BlendW-1:0] SatMin = -SatMax;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] stage_q, stage_d;

    // Control strobes from the output process
    logic capture_en;
    logic stage1_en;
    logic stage2_en;
    logic stage3_en;
    logic finish_en;

    // Captured position (stage 0)
    logic signed [EVAL_WIDTH-1:0]     mg_q, mg_d;
    logic signed [EVAL_WIDTH-1:0]     eg_q, eg_d;
    logic        [MATERIAL_WIDTH-1:0] mat_w_q, mat_w_d;
    logic        [MATERIAL_WIDTH-1:0] mat_b_q, mat_b_d;
    logic                             insuf_q, insuf_d;
    logic                             wtm_q, wtm_d;

    // Pipeline stage registers
    logic        [8:0]                phase_q, phase_d;
    logic signed [ProdW-1:0]          prod_mg_q, prod_mg_d;
    logic signed [ProdW-1:0]          prod_eg_q, prod_eg_d;
    logic signed [BlendW-1:0]         blend_q, blend_d;

    // Result registers
    logic signed [EVAL_WIDTH-1:0]     taper_eval_q, taper_eval_d;
    logic        [8:0]                taper_phase_q, taper_phase_d;

    // Datapath combinational terms
    logic        [TotW-1:0]           total;
    logic        [TotW-1:0]           excess;
    logic        [TotW-1:0]           scaled;
    logic        [8:0]                phase_calc;
    logic        [8:0]                eg_weight;
    logic signed [ProdW-1:0]          sum_calc;
    logic signed [ProdW-1:0]          sum_shift;
    logic signed [EVAL_WIDTH-1:0]     sat_calc;
    logic signed [EVAL_WIDTH-1:0]     eval_calc;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            stage_q <= 2'd0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    // FSM next state: clear wins over everything, including a start in IDLE
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        if (bus.clear_eval) begin
            state_d = StIdle;
            stage_d = 2'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.eval_valid) begin
                        state_d = StBusy;
                        stage_d = 2'd0;
                    end
                end
                StBusy: begin
                    if (stage_q == 2'd3) begin
                        state_d = StDone;
                        stage_d = 2'd0;
                    end else begin
                        stage_d = stage_q + 2'd1;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                    stage_d = 2'd0;
                end
            endcase
        end
    end

    // FSM outputs: stage strobes and the valid flag
    always_comb begin
        capture_en = (state_q == StIdle) && bus.eval_valid && !bus.clear_eval;
        stage1_en  = (state_q == StBusy) && (stage_q == 2'd0);
        stage2_en  = (state_q == StBusy) && (stage_q == 2'd1);
        stage3_en  = (state_q == StBusy) && (stage_q == 2'd2);
        finish_en  = (state_q == StBusy) && (stage_q == 2'd3) && !bus.clear_eval;
        bus.taper_valid = (state_q == StDone);
    end

    // Stage 1: phase from total non-king material, clamped to 0..256
    always_comb begin
        total  = TotW'(mat_w_q) + TotW'(mat_b_q);
        excess = total - MatEg;
        scaled = excess >> MATERIAL_SHIFT;
        if (total <= MatEg) begin
            phase_calc = 9'd0;
        end else if (scaled > PhaseFull) begin
            phase_calc = 9'd256;
        end else begin
            phase_calc = scaled[8:0];
        end
    end

    // Stages 2-4: weighted products, floor blend, saturate and orient
    always_comb begin
        eg_weight = 9'd256 - phase_q;
        sum_calc  = prod_mg_q + prod_eg_q;
        sum_shift = sum_calc >>> 8;
        if (insuf_q) begin
            sat_calc = '0;
        end else if (blend_q > SatMax) begin
            sat_calc = SatMax[EVAL_WIDTH-1:0];
        end else if (blend_q < SatMin) begin
            sat_calc = SatMin[EVAL_WIDTH-1:0];
        end else begin
            sat_calc = blend_q[EVAL_WIDTH-1:0];
        end
        eval_calc = wtm_q ? sat_calc : -sat_calc;
    end

    // Datapath next state: each register loads only on its own stage strobe
    always_comb begin
        mg_d          = mg_q;
        eg_d          = eg_q;
        mat_w_d       = mat_w_q;
        mat_b_d       = mat_b_q;
        insuf_d       = insuf_q;
        wtm_d         = wtm_q;
        phase_d       = phase_q;
        prod_mg_d     = prod_mg_q;
        prod_eg_d     = prod_eg_q;
        blend_d       = blend_q;
        taper_eval_d  = taper_eval_q;
        taper_phase_d = taper_phase_q;
        if (capture_en) begin
            mg_d    = bus.eval_mg;
            eg_d    = bus.eval_eg;
            mat_w_d = bus.material_white;
            mat_b_d = bus.material_black;
            insuf_d = bus.insufficient_material;
            wtm_d   = bus.white_to_move;
        end
        if (stage1_en) begin
            phase_d = phase_calc;
        end
        if (stage2_en) begin
            prod_mg_d = ProdW'(mg_q) * ProdW'($signed({1'b0, phase_q}));
            prod_eg_d = ProdW'(eg_q) * ProdW'($signed({1'b0, eg_weight}));
        end
        if (stage3_en) begin
            blend_d = BlendW'(sum_shift);
        end
        if (finish_en) begin
            taper_eval_d  = eval_calc;
            taper_phase_d = phase_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mg_q          <= '0;
            eg_q          <= '0;
            mat_w_q       <= '0;
            mat_b_q       <= '0;
            insuf_q       <= 1'b0;
            wtm_q         <= 1'b0;
            phase_q       <= '0;
            prod_mg_q     <= '0;
            prod_eg_q     <= '0;
            blend_q       <= '0;
            taper_eval_q  <= '0;
            taper_phase_q <= '0;
        end else begin
            mg_q          <= mg_d;
            eg_q          <= eg_d;
            mat_w_q       <= mat_w_d;
            mat_b_q       <= mat_b_d;
            insuf_q       <= insuf_d;
            wtm_q         <= wtm_d;
            phase_q       <= phase_d;
            prod_mg_q     <= prod_mg_d;
            prod_eg_q     <= prod_eg_d;
            blend_q       <= blend_d;
            taper_eval_q  <= taper_eval_d;
            taper_phase_q <= taper_phase_d;
        end
    end

    assign bus.taper_eval  = taper_eval_q;
    assign bus.taper_phase = taper_phase_q;

endmodule

// File: doc/evaluate_taper.md
EVALUATE_TAPER -- requirements
Module: evaluate_taper

Interface
REQ-001 SHALL have parameter EVAL_WIDTH, default 0 (must be overridden), width of all signed evaluation values.
REQ-002 SHALL have parameter MATERIAL_WIDTH, default 32, width of the material inputs.
REQ-003 SHALL have parameter MATERIAL_EG, default 1000, total material at or below which phase is pure endgame.
REQ-004 SHALL have parameter MATERIAL_SHIFT, default 4, right shift converting excess material to phase units.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port eval_valid  input  1  level; general evaluation inputs are stable while high.
REQ-008 SHALL have port clear_eval  input  1  abort/clear request for the current position.
REQ-009 SHALL have port eval_mg  input  EVAL_WIDTH signed  middlegame score, white perspective.
REQ-010 SHALL have port eval_eg  input  EVAL_WIDTH signed  endgame score, white perspective.
REQ-011 SHALL have port material_white  input  MATERIAL_WIDTH  unsigned white non-king material.
REQ-012 SHALL have port material_black  input  MATERIAL_WIDTH  unsigned black non-king material.
REQ-013 SHALL have port insufficient_material  input  1  draw-by-material flag.
REQ-014 SHALL have port white_to_move  input  1  side to move.
REQ-015 SHALL have port taper_eval  output  EVAL_WIDTH signed  blended score, side-to-move perspective.
REQ-016 SHALL have port taper_phase  output  9  phase used, 0..256.
REQ-017 SHALL have port taper_valid  output  1  result valid; held until clear_eval or reset.

Function
REQ-018 SHALL implement states IDLE, BUSY, DONE with a 2-bit stage counter used in BUSY.
REQ-019 SHALL, in IDLE with eval_valid=1 and clear_eval=0, register all inputs (stage 0), enter BUSY, counter=0.
REQ-020 SHALL sample inputs only at the IDLE->BUSY transition; later input changes do not affect the result.
REQ-021 SHALL compute stage 1: total = material_white + material_black (MATERIAL_WIDTH+1 bits); phase = 0 if total <= MATERIAL_EG, else min(256, (total - MATERIAL_EG) >> MATERIAL_SHIFT).
REQ-022 SHALL compute stage 2: products mg*phase and eg*(256 - phase), each EVAL_WIDTH+10 bits signed.
REQ-023 SHALL compute stage 3: blend = (sum of products) arithmetic-shifted right by 8 (rounds toward negative infinity).
REQ-024 SHALL compute stage 4: r = 0 if insufficient_material; else blend saturated to +/-(2^(EVAL_WIDTH-1) - 1); taper_eval = white_to_move ? r : -r.
REQ-025 SHALL, on the clock edge completing stage 4, load taper_eval and taper_phase, set taper_valid=1, enter DONE.
REQ-026 SHALL give latency 4: capture at edge N, taper_valid first high after edge N+4.
REQ-027 SHALL remain in DONE, holding outputs, while clear_eval=0, regardless of eval_valid.
REQ-028 SHALL, when clear_eval=1 in any state, go to IDLE and drive taper_valid=0 after that edge; an in-flight calculation is discarded.
REQ-029 SHALL give clear_eval priority over a simultaneous IDLE start condition, so no capture occurs on that edge.
REQ-030 SHALL start a new calculation from IDLE on the first edge after clear at which eval_valid=1 and clear_eval=0.
REQ-031 SHALL ignore eval_valid while in BUSY.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, enter IDLE with counter=0, taper_valid=0, taper_eval=0, taper_phase=0, overriding clear_eval and eval_valid.
REQ-033 SHALL, on reset during BUSY, discard the in-flight result; no taper_valid pulse follows.

Verification (EVAL_WIDTH=32, default parameters)
REQ-034 SHALL test: material 3900/3900, mg=120, eg=-40, white_to_move=1 -> phase=256, taper_eval=120, taper_valid after 4 edges.
REQ-035 SHALL test: material 500/500, mg=120, eg=-40, white_to_move=0 -> phase=0, taper_eval=40.
REQ-036 SHALL test: material 1524/1524, mg=100, eg=300 -> phase=128, taper_eval=200; eg=-301 -> taper_eval=-101 (floor).
REQ-037 SHALL test: insufficient_material=1, any scores -> taper_eval=0, taper_valid asserted.
REQ-038 SHALL test: clear_eval 2 edges after capture -> taper_valid stays 0; re-asserting eval_valid with new inputs -> fresh correct result 4 edges later.
REQ-039 SHALL test: mg=eg=2^31-1, phase 256, white_to_move=0 -> taper_eval=-(2^31-1); reset in BUSY -> all outputs 0, no valid.
